// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector multiply-accumulate block.
package matvec_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MAC  = ST_MAC,
        DONE = ST_DONE
    } state_t;

    // Result width that holds N*(2^W-1)^2 without overflow.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate: acc + a*b, purely combinational.
module mac_unit #(
    parameter int W    = 2,
    parameter int ACCW = 5
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [ACCW-1:0] acc,
    output logic [ACCW-1:0] sum
);

    // Operands are widened first so the product keeps full precision.
    assign sum = acc + ACCW'(a) * ACCW'(b);

endmodule

// File: rtl/matvec_mac.sv
// Sequential N x N matrix by N-vector multiplier, one MAC per clock.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MAC   | stepping through mat[r][c]*vec[c], one element per edge
// DONE  | result valid on vec_out until out_ready
module matvec_mac
    import matvec_pkg::*;
#(
    parameter int  N    = 2,
    parameter int  W    = 2,
    localparam int ACCW = acc_width(N, W)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N*N*W-1:0]    mat_in,
    input  logic [N*W-1:0]      vec_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N*ACCW-1:0]   vec_out,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int CW = $clog2(N);

    state_t              state_q;
    state_t              state_d;
    logic [N*N*W-1:0]    mat_q;
    logic [N*W-1:0]      vec_q;
    logic [ACCW-1:0]     acc [N];
    logic [CW-1:0]       r_q;
    logic [CW-1:0]       c_q;
    logic [W-1:0]        mac_a;
    logic [W-1:0]        mac_b;
    logic [ACCW-1:0]     mac_acc;
    logic [ACCW-1:0]     mac_sum;
    logic                last_step;

    assign last_step = (r_q == CW'(N - 1)) && (c_q == CW'(N - 1));

    // Row/column select feeding the single shared MAC.
    assign mac_a   = mat_q[(int'(r_q) * N + int'(c_q)) * W +: W];
    assign mac_b   = vec_q[int'(c_q) * W +: W];
    assign mac_acc = acc[r_q];

    mac_unit #(
        .W    (W),
        .ACCW (ACCW)
    ) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .acc (mac_acc),
        .sum (mac_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode from registered state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MAC;
            end
            MAC: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, accumulator update and row/column stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_q <= '0;
            vec_q <= '0;
            r_q   <= '0;
            c_q   <= '0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else if (state_q == IDLE && in_valid) begin
            mat_q <= mat_in;
            vec_q <= vec_in;
            r_q   <= '0;
            c_q   <= '0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else if (state_q == MAC) begin
            acc[r_q] <= mac_sum;
            if (c_q == CW'(N - 1)) begin
                c_q <= '0;
                r_q <= (r_q == CW'(N - 1)) ? '0 : r_q + 1'b1;
            end else begin
                c_q <= c_q + 1'b1;
            end
        end
    end

    // Result vector is a direct view of the accumulators.
    always_comb begin
        vec_out = '0;
        for (int i = 0; i < N; i++) vec_out[i * ACCW +: ACCW] = acc[i];
    end

endmodule

// File: tb/tb_matvec_mac.sv
// Self-checking bench for matvec_mac: N=2/W=2 and N=3/W=4 instances.
module tb_matvec_mac;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        iv;
    logic        ordy;
    logic [63:0] m_drv;
    logic [63:0] v_drv;

    logic [7:0]  a_mat;
    logic [3:0]  a_vec;
    logic        a_in_valid, a_in_ready, a_out_valid;
    logic [9:0]  a_vec_out;

    logic [35:0] b_mat;
    logic [11:0] b_vec;
    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [29:0] b_vec_out;

    logic        cur_in_ready, cur_out_valid;
    logic [63:0] cur_vec_out;

    int n_checks = 0;
    int n_fail   = 0;

    matvec_mac #(.N(2), .W(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .mat_in(a_mat), .vec_in(a_vec),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .vec_out(a_vec_out),
        .out_valid(a_out_valid), .out_ready(ordy)
    );

    matvec_mac #(.N(3), .W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .mat_in(b_mat), .vec_in(b_vec),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .vec_out(b_vec_out),
        .out_valid(b_out_valid), .out_ready(ordy)
    );

    always #5 clk = ~clk;

    // Route shared stimulus to the selected instance and observe it.
    always_comb begin
        a_mat         = m_drv[7:0];
        a_vec         = v_drv[3:0];
        b_mat         = m_drv[35:0];
        b_vec         = v_drv[11:0];
        a_in_valid    = iv & ~sel;
        b_in_valid    = iv & sel;
        cur_in_ready  = sel ? b_in_ready : a_in_ready;
        cur_out_valid = sel ? b_out_valid : a_out_valid;
        cur_vec_out   = sel ? 64'(b_vec_out) : 64'(a_vec_out);
    end

    typedef struct packed {
        logic [7:0] mat;
        logic [3:0] vec;
        logic [9:0] exp;
    } vec_rec_t;

    vec_rec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: sum over columns of mat[r][c]*vec[c], packed per row.
    function automatic logic [63:0] model(input int n, input int w,
                                          input logic [63:0] m, input logic [63:0] v);
        logic [63:0] res;
        longint      s;
        longint      mask;
        int          accw;
        accw = 2 * w + ((n <= 2) ? 1 : 2);
        mask = (longint'(1) << w) - 1;
        res  = '0;
        for (int r = 0; r < n; r++) begin
            s = 0;
            for (int c = 0; c < n; c++)
                s += ((longint'(m) >> ((r * n + c) * w)) & mask) *
                     ((longint'(v) >> (c * w)) & mask);
            res |= 64'(s) << (r * accw);
        end
        return res;
    endfunction

    task automatic op(input logic s, input logic [63:0] m, input logic [63:0] v,
                      input logic hold, input logic tog,
                      output logic [63:0] res, output int lat);
        int n;
        @(negedge clk);
        sel = s; m_drv = m; v_drv = v; iv = 1'b1; ordy = ~hold;
        #1;
        n = 0;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        @(negedge clk);
        iv  = 1'b0;
        lat = 0;
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (tog) begin
                iv    = 1'($urandom_range(0, 1));
                m_drv = {$urandom, $urandom};
                v_drv = {$urandom, $urandom};
            end
        end
        iv = 1'b0;
        if (lat >= 100) chk("done_timeout", 64'(lat), 64'(0));
        res = cur_vec_out;
        if (!hold) begin
            @(negedge clk);
            chk("valid_pulse", 64'(cur_out_valid), 64'(0));
            chk("ready_back", 64'(cur_in_ready), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, exp, ident, bvec, held;
        int          lat, n, prev_rdy;
        int          acc_cyc[$];

        tbl[0] = '{mat: 8'h39, vec: 4'h6, exp: {5'd6,  5'd4}};
        tbl[1] = '{mat: 8'hFF, vec: 4'hF, exp: {5'd18, 5'd18}};
        tbl[2] = '{mat: 8'h00, vec: 4'h0, exp: {5'd0,  5'd0}};
        tbl[3] = '{mat: 8'hE4, vec: 4'hB, exp: {5'd12, 5'd2}};

        clk = 0; reset_n = 0; sel = 0; iv = 0; ordy = 1; m_drv = '0; v_drv = '0;
        #2;
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_a_vec_out", 64'(a_vec_out), 64'(0));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
        chk("rst_b_vec_out", 64'(b_vec_out), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // Directed table on the 2x2 instance.
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 64'(tbl[i].mat), 64'(tbl[i].vec), 1'b0, 1'b0, res, lat);
            chk("tbl_result", res, 64'(tbl[i].exp));
            chk("tbl_latency", 64'(lat), 64'(4));
        end

        // Random operands against the reference, both sizes.
        for (int i = 0; i < 12; i++) begin
            m_drv = '0;
            exp = {$urandom, $urandom};
            bvec = {$urandom, $urandom};
            op(1'b0, exp, bvec, 1'b0, 1'b0, res, lat);
            chk("rand_a", res, model(2, 2, exp, bvec));
        end
        for (int i = 0; i < 6; i++) begin
            exp = {$urandom, $urandom};
            bvec = {$urandom, $urandom};
            op(1'b1, exp, bvec, 1'b0, 1'b0, res, lat);
            chk("rand_b", res, model(3, 4, exp, bvec));
            chk("rand_b_latency", 64'(lat), 64'(9));
        end

        // Identity matrix on the 3x3 instance.
        ident = '0;
        for (int i = 0; i < 3; i++) ident[(i * 3 + i) * 4 +: 4] = 4'd1;
        bvec = 64'd5 | (64'd6 << 4) | (64'd7 << 8);
        op(1'b1, ident, bvec, 1'b0, 1'b0, res, lat);
        chk("ident_result", res, 64'd5 | (64'd6 << 10) | (64'd7 << 20));
        chk("ident_latency", 64'(lat), 64'(9));

        // Back-to-back acceptances with in_valid and out_ready held high.
        @(negedge clk);
        sel = 1; m_drv = ident; v_drv = bvec; iv = 1; ordy = 1;
        #1;
        prev_rdy = int'(b_in_ready);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (prev_rdy == 1 && !b_in_ready) acc_cyc.push_back(t);
            prev_rdy = int'(b_in_ready);
            if (acc_cyc.size() == 2) break;
        end
        iv = 0;
        chk("b2b_count", 64'(acc_cyc.size()), 64'(2));
        chk("b2b_interval", 64'((acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1), 64'(11));
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain_result", 64'(b_vec_out), 64'd5 | (64'd6 << 10) | (64'd7 << 20));

        // Backpressure: hold DONE, pulse in_valid with fresh operands.
        exp = 64'h9C;
        bvec = 64'h7;
        op(1'b0, exp, bvec, 1'b1, 1'b0, held, lat);
        chk("bp_result", held, model(2, 2, exp, bvec));
        for (int t = 0; t < 5; t++) begin
            chk("bp_vec_stable", cur_vec_out, held);
            chk("bp_in_ready", 64'(cur_in_ready), 64'(0));
            chk("bp_out_valid", 64'(cur_out_valid), 64'(1));
            iv = (t % 2 == 0);
            m_drv = {$urandom, $urandom};
            v_drv = {$urandom, $urandom};
            @(negedge clk);
        end
        iv = 0; ordy = 1;
        @(negedge clk);
        chk("bp_release_ready", 64'(cur_in_ready), 64'(1));
        chk("bp_release_valid", 64'(cur_out_valid), 64'(0));
        chk("bp_idle_vec_hold", cur_vec_out, held);
        @(negedge clk);
        chk("bp_idle_vec_hold2", cur_vec_out, held);

        // in_valid and operand inputs toggling during MAC.
        for (int i = 0; i < 4; i++) begin
            exp = {$urandom, $urandom};
            bvec = {$urandom, $urandom};
            op(1'b0, exp, bvec, 1'b0, 1'b1, res, lat);
            chk("ignore_toggle", res, model(2, 2, exp, bvec));
        end

        // Asynchronous reset after two MAC steps.
        @(negedge clk);
        sel = 0; m_drv = 64'hFF; v_drv = 64'hF; iv = 1; ordy = 1;
        @(posedge clk);
        @(negedge clk);
        iv = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_mac_partial", 64'(a_vec_out), 64'd18);
        chk("mid_mac_in_ready", 64'(a_in_ready), 64'(0));
        reset_n = 0;
        #1;
        chk("async_rst_vec_out", 64'(a_vec_out), 64'(0));
        chk("async_rst_out_valid", 64'(a_out_valid), 64'(0));
        chk("async_rst_in_ready", 64'(a_in_ready), 64'(1));
        @(negedge clk);
        reset_n = 1;
        exp = {$urandom, $urandom};
        bvec = {$urandom, $urandom};
        op(1'b0, exp, bvec, 1'b0, 1'b0, res, lat);
        chk("post_rst_result", res, model(2, 2, exp, bvec));
        chk("post_rst_latency", 64'(lat), 64'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
